accumulator_unit: RTL and testbench

//  Parametrised accumulator bank for the datapath.
//  - Holds NUM_ACC accumulators of WIDTH bits.
//  - Operand comes from data, in_port, an accumulator, or zero.
//  - Executes single-cycle ALU ops and a multi-cycle shift-add multiply.
//  - Exports zero/positive/carry/overflow flags for the control unit's branch logic.
//  - Command interface is a valid/ready handshake, so the sequencer stalls during multiply.

---
 rtl/acc_pkg.sv | 26 ++
 rtl/shift_add_mul.sv | 71 +++++++
 rtl/accumulator_unit.sv | 173 +++++++++++++++++
 tb/tb_accumulator_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared encodings and FSM state type for the accumulator bank
package acc_pkg;

    // Operation encodings
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // Operand source encodings
    localparam logic [1:0] SRC_DATA = 2'b00;
    localparam logic [1:0] SRC_PORT = 2'b01;
    localparam logic [1:0] SRC_ACC  = 2'b10;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    // Command FSM: IDLE accepts commands, MUL stalls while the multiplier iterates
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - unsigned shift-add multiplier, one partial product per cycle
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset (aborts a multiply)
//   start        latch a/b and begin; ignored while busy
//   a, b         multiplicand / multiplier (WIDTH bits)
//   busy         high for exactly WIDTH cycles after the start edge
//   last         high in the final busy cycle; product is final at the edge that ends it
//   done         one-cycle pulse in the cycle after the final edge
//   product      2*WIDTH-bit product including the current cycle's partial product
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 last,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [CNT_W-1:0]   count;

    // The product is exported including this cycle's addend so the owner can
    // write the result on the same edge that retires the last iteration.
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
        last      = busy && (count == LAST_CNT);
        product   = prod_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
                count  <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                prod   <= prod_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/accumulator_unit.sv
// rtl/accumulator_unit.sv - accumulator bank with single-cycle ALU and multi-cycle multiply
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   data, in_port         external operand sources
//   cmd_valid/cmd_ready   command handshake; ready drops while a multiply runs
//   op, src, src_idx      operation, operand select, source accumulator for src=ACC
//   wr_idx                destination (and left operand) accumulator
//   rd_idx, acc_out       combinational read port
//   aeq0, apos            zero / strictly-positive flags of acc_out
//   carry, ovf            registered flags of the last flag-writing operation
//   busy, done            multiply in progress / one-cycle completion pulse
module accumulator_unit
    import acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4,
    localparam int IDX_W  = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] in_port,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       op,
    input  logic [1:0]       src,
    input  logic [IDX_W-1:0] src_idx,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] acc_out,
    output logic             aeq0,
    output logic             apos,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0]   acc [NUM_ACC];
    logic [WIDTH-1:0]   a_val;
    logic [WIDTH-1:0]   b_val;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product;
    logic [IDX_W-1:0]   mul_idx;
    acc_state_e         state;
    acc_state_e         state_next;

    assign accept    = cmd_valid && cmd_ready;
    assign mul_start = accept && (op == OP_MUL);

    // Operand selection
    always_comb begin
        a_val = acc[wr_idx];
        b_val = '0;
        unique case (src)
            SRC_DATA: b_val = data;
            SRC_PORT: b_val = in_port;
            SRC_ACC:  b_val = acc[src_idx];
            SRC_ZERO: b_val = '0;
        endcase
    end

    // Single-cycle ALU; the MUL arm is never written back from here
    always_comb begin
        sum_ext   = {1'b0, a_val} + {1'b0, b_val};
        diff_ext  = {1'b0, a_val} - {1'b0, b_val};
        alu_res   = a_val;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        unique case (op)
            OP_LOAD: alu_res = b_val;
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a_val[WIDTH-1] == b_val[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
                alu_ovf   = (a_val[WIDTH-1] != b_val[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_AND: alu_res = a_val & b_val;
            OP_OR:  alu_res = a_val | b_val;
            OP_SHL: begin
                alu_res   = {a_val[WIDTH-2:0], 1'b0};
                alu_carry = a_val[WIDTH-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, a_val[WIDTH-1:1]};
                alu_carry = a_val[0];
            end
            OP_MUL: alu_res = a_val;
        endcase
    end

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a_val),
        .b       (b_val),
        .busy    (mul_busy),
        .last    (mul_last),
        .done    (done),
        .product (mul_product)
    );

    // Command FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (mul_start) state_next = MUL;
            MUL:  if (mul_last)  state_next = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = mul_busy;

    // Accumulator bank and flags. Single-cycle writes and multiply completion
    // are mutually exclusive because commands are refused while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc[i] <= '0;
            end
            carry   <= 1'b0;
            ovf     <= 1'b0;
            mul_idx <= '0;
        end else begin
            if (accept && (op != OP_MUL)) begin
                acc[wr_idx] <= alu_res;
                carry       <= alu_carry;
                ovf         <= alu_ovf;
            end
            if (mul_start) begin
                mul_idx <= wr_idx;
            end
            if (mul_last) begin
                acc[mul_idx] <= mul_product[WIDTH-1:0];
                carry        <= |mul_product[2*WIDTH-1:WIDTH];
                ovf          <= 1'b0;
            end
        end
    end

    // Read port: combinational, no bypass of an in-flight write
    assign acc_out = acc[rd_idx];
    assign aeq0    = (acc_out == '0);
    assign apos    = !acc_out[WIDTH-1] && !aeq0;

endmodule

// File: tb/tb_accumulator_unit.sv
// tb/tb_accumulator_unit.sv - directed self-checking bench for accumulator_unit
module tb_accumulator_unit;

    localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011;
    localparam logic [2:0] OR_  = 3'b100, SHL = 3'b101, SHR = 3'b110, MULT = 3'b111;
    localparam logic [1:0] S_DATA = 2'b00, S_PORT = 2'b01, S_ACC = 2'b10, S_ZERO = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = '0;
    logic [7:0] in_port = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] op = '0;
    logic [1:0] src = '0;
    logic [1:0] src_idx = '0;
    logic [1:0] wr_idx = '0;
    logic [1:0] rd_idx = '0;
    logic [7:0] acc_out;
    logic       aeq0, apos, carry, ovf, busy, done;

    int checks = 0;
    int failures = 0;

    accumulator_unit #(.WIDTH(8), .NUM_ACC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .in_port   (in_port),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .op        (op),
        .src       (src),
        .src_idx   (src_idx),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .acc_out   (acc_out),
        .aeq0      (aeq0),
        .apos      (apos),
        .carry     (carry),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [1:0] si,
                         input logic [1:0] wi, input logic [7:0] d, input logic [7:0] ip);
        op = o; src = s; src_idx = si; wr_idx = wi; data = d; in_port = ip;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic read(input logic [1:0] r);
        rd_idx = r;
        #1;
    endtask

    int  n;
    int  dones;
    logic held_ok;

    initial begin
        // 1: reset and idle
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        for (int r = 0; r < 4; r++) begin
            read(2'(r));
            check($sformatf("reset_acc%0d", r), acc_out, 8'h00);
        end
        check("reset_aeq0", aeq0, 1'b1);
        check("reset_apos", apos, 1'b0);
        check("reset_carry", carry, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_done", done, 1'b0);

        // 2: loads from data and in_port
        issue(LOAD, S_DATA, 2'd0, 2'd0, 8'hAA, 8'h00);
        issue(LOAD, S_PORT, 2'd0, 2'd1, 8'h00, 8'h55);
        read(2'd0); check("load_acc0", acc_out, 8'hAA); check("load_apos0", apos, 1'b0);
        read(2'd1); check("load_acc1", acc_out, 8'h55); check("load_apos1", apos, 1'b1);
        read(2'd2); check("load_acc2", acc_out, 8'h00);
        read(2'd3); check("load_acc3", acc_out, 8'h00);

        // 3: ADD wrap with carry, ADD signed overflow
        issue(ADD, S_DATA, 2'd0, 2'd1, 8'hAB, 8'h00);
        read(2'd1);
        check("add_wrap_res", acc_out, 8'h00);
        check("add_wrap_carry", carry, 1'b1);
        check("add_wrap_aeq0", aeq0, 1'b1);
        check("add_wrap_ovf", ovf, 1'b0);
        issue(LOAD, S_DATA, 2'd0, 2'd2, 8'h7F, 8'h00);
        check("load_clears_carry", carry, 1'b0);
        issue(ADD, S_DATA, 2'd0, 2'd2, 8'h01, 8'h00);
        read(2'd2);
        check("add_ovf_res", acc_out, 8'h80);
        check("add_ovf_ovf", ovf, 1'b1);
        check("add_ovf_carry", carry, 1'b0);

        // 4: SUB borrow, SHL carry-out
        issue(LOAD, S_DATA, 2'd0, 2'd3, 8'h03, 8'h00);
        issue(SUB, S_DATA, 2'd0, 2'd3, 8'h05, 8'h00);
        read(2'd3);
        check("sub_res", acc_out, 8'hFE);
        check("sub_borrow", carry, 1'b1);
        check("sub_ovf", ovf, 1'b0);
        issue(LOAD, S_DATA, 2'd0, 2'd3, 8'h81, 8'h00);
        issue(SHL, S_DATA, 2'd0, 2'd3, 8'hFF, 8'h00);
        read(2'd3);
        check("shl_res", acc_out, 8'h02);
        check("shl_carry", carry, 1'b1);

        // self-add through the accumulator operand path: 0xAA+0xAA
        issue(ADD, S_ACC, 2'd0, 2'd0, 8'h00, 8'h00);
        read(2'd0);
        check("self_add_res", acc_out, 8'h54);
        check("self_add_carry", carry, 1'b1);
        check("self_add_ovf", ovf, 1'b1);
        read(2'd2);
        check("self_add_other", acc_out, 8'h80);

        // AND / OR / SHR chain on acc1
        issue(LOAD, S_DATA, 2'd0, 2'd1, 8'hF0, 8'h00);
        issue(AND_, S_DATA, 2'd0, 2'd1, 8'h3C, 8'h00);
        read(2'd1); check("and_res", acc_out, 8'h30);
        issue(OR_, S_PORT, 2'd0, 2'd1, 8'h00, 8'h05);
        read(2'd1); check("or_res", acc_out, 8'h35);
        issue(SHR, S_ZERO, 2'd0, 2'd1, 8'h00, 8'h00);
        read(2'd1);
        check("shr_res", acc_out, 8'h1A);
        check("shr_carry", carry, 1'b1);

        // 5: MUL 0x0D * 0x0B with an ADD held during busy
        issue(LOAD, S_DATA, 2'd0, 2'd1, 8'h0D, 8'h00);
        op = MULT; src = S_DATA; wr_idx = 2'd1; data = 8'h0B; cmd_valid = 1'b1;
        tick();
        op = ADD; data = 8'h01;
        check("mul_busy_start", busy, 1'b1);
        check("mul_ready_low", cmd_ready, 1'b0);
        rd_idx = 2'd1;
        n = 1;
        dones = 0;
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (acc_out !== 8'h0D) held_ok = 1'b0;
            if (done) dones++;
            tick();
            if (!busy) break;
            n++;
        end
        check("mul_held_add_ignored", held_ok, 1'b1);
        check("mul_busy_cycles", n, 8);
        check("mul_done_pulse", done, 1'b1);
        check("mul_no_early_done", dones, 0);
        check("mul_res", acc_out, 8'h8F);
        check("mul_carry", carry, 1'b0);
        check("mul_ready_on_done", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("held_add_res", acc_out, 8'h90);
        check("done_one_cycle", done, 1'b0);

        // MUL 0x20 * 0x10 overflows the low byte
        issue(LOAD, S_DATA, 2'd0, 2'd2, 8'h20, 8'h00);
        issue(MULT, S_DATA, 2'd0, 2'd2, 8'h10, 8'h00);
        dones = 0;
        for (int i = 0; i < 20 && dones == 0; i++) begin
            if (done) dones++;
            else tick();
        end
        check("mul2_done_seen", dones, 1);
        read(2'd2);
        check("mul2_res", acc_out, 8'h00);
        check("mul2_carry", carry, 1'b1);
        check("mul2_ovf", ovf, 1'b0);
        check("mul2_aeq0", aeq0, 1'b1);

        // 6: reset on the 4th busy cycle aborts the multiply
        issue(LOAD, S_DATA, 2'd0, 2'd0, 8'h0D, 8'h00);
        issue(MULT, S_DATA, 2'd0, 2'd0, 8'h0B, 8'h00);
        tick(); tick(); tick();
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        for (int r = 0; r < 4; r++) begin
            read(2'(r));
            check($sformatf("abort_acc%0d", r), acc_out, 8'h00);
        end
        issue(LOAD, S_DATA, 2'd0, 2'd3, 8'h42, 8'h00);
        read(2'd3);
        check("post_abort_load", acc_out, 8'h42);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort_no_done", dones, 0);
        read(2'd0);
        check("abort_acc0_stays", acc_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
